add_sub_seq: RTL
================

Name: add_sub_seq

Overview:
- Multi-cycle 16-bit two's-complement add/subtract unit for the ODE solver datapath.
- Computes A+B or A−B with a signed overflow flag, one SLICE-bit chunk per clock.
- Trades latency for a short carry path; sits between solver control and operand/result registers.
- Valid/ready handshake on both input and output.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE
SLICE, 4, bits processed per CALC cycle; NSLICE = WIDTH/SLICE

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept; high only in IDLE
op  input  1  0 = A+B, 1 = A−B
a  input  WIDTH  operand A, signed two's complement
b  input  WIDTH  operand B, signed two's complement
out_valid  output  1  result/overflow valid; high only in DONE
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference, wraps modulo 2^WIDTH
overflow  output  1  signed overflow of the operation

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE; in_ready = 1; out_valid = 0; result = 0; overflow = 0; slice counter = 0; carry = 0.
  - Reset mid-operation discards the operation silently.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a; latch b (bitwise inverted if op = 1); carry = op; cnt = 0; go to CALC.
- CALC:
  - in_ready = 0.
  - Each clock adds slice cnt (bits cnt*SLICE+SLICE−1 : cnt*SLICE) of latched A and latched B' plus carry.
  - Writes that slice of result; stores the slice carry-out; increments cnt.
  - On the edge that processes slice NSLICE−1: overflow = carry into MSB XOR carry out of MSB; go to DONE; out_valid = 1.
- DONE:
  - out_valid = 1; result and overflow held stable.
  - On out_ready: out_valid = 0 and state = IDLE at that edge.
  - Input is not accepted in the same cycle.
- Latency:
  - Accept edge T → out_valid high after edge T+NSLICE (T+4 at default).
  - Minimum issue interval NSLICE+2 cycles when out_ready is held high.
- Input sampling:
  - a, b, op are sampled only at accept; changes during CALC/DONE are ignored.
  - in_valid during CALC/DONE is ignored, with no side effect.
- Result is undefined/partial during CALC and must not be consumed before out_valid.
- Arithmetic:
  - Subtraction is A + ~B + 1.
  - Carry-out from the MSB is discarded, except for the overflow computation.
  - Edge cases: −32768 − 1 overflows; 0 − (−32768) overflows; −32768 + −32768 → result 0, overflow 1.

Optional Feature:
ADD_SUB_SATURATE_EN
- Defined: when overflow = 1, result is clamped in DONE.
  - 0x7FFF if the true result is positive (A sign = 0); 0x8000 if negative.
  - overflow is still reported as 1.
- Undefined: result wraps modulo 2^WIDTH.
- Latency and handshake are identical either way.

Decomposition:
- Package add_sub_pkg:
  - state enum {IDLE, CALC, DONE}
  - op encodings OP_ADD = 0, OP_SUB = 1
  - SAT_MAX/SAT_MIN constants derived from WIDTH
- Sub-module slice_adder:
  - SLICE-bit ripple adder with cin.
  - Outputs sum, cout, and carry into its MSB (needed for overflow on the last slice).
  - Instantiated once and time-multiplexed across slices.

Test Plan:
- Reset then idle:
  - Expect in_ready = 1, out_valid = 0, result = 0, overflow = 0.
  - Assert rst_n low mid-CALC → next cycle in state IDLE with in_ready = 1; no out_valid pulse follows.
- Add, a = 0x1234, b = 0x0FF1, op = 0:
  - out_valid exactly 4 cycles after accept; result = 0x2225, overflow = 0.
- Subtract, a = 0x0005, b = 0x0007, op = 1 → result = 0xFFFE, overflow = 0.
- Overflow cases:
  - a = 0x7FFF, b = 0x0001, op = 0 → result = 0x8000, overflow = 1 (0x7FFF with ADD_SUB_SATURATE_EN).
  - a = 0x8000, b = 0x0001, op = 1 → result = 0x7FFF, overflow = 1 (0x8000 saturated).
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid; result stays stable and in_ready stays 0.
  - Change a/b/in_valid during CALC → no effect on result.
  - Release out_ready → out_valid falls, in_ready rises next cycle.
- Back-to-back, out_ready tied high:
  - Issue 100 random ops; results match reference wrap/overflow arithmetic.
  - Issue interval is exactly 6 cycles.

Source files
------------

// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_pkg
// Description : Shared types and constants for the sequential add/subtract
//               unit: FSM state encoding, opcode values and the saturation
//               limits used when ADD_SUB_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Datapath width the saturation limits are derived from.
    localparam int DATA_WIDTH = 16;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage : add_sub_pkg
`default_nettype wire

// File: rtl/slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : slice_adder
// Description : SLICE-bit ripple-carry adder. Besides the sum and carry-out it
//               exposes the carry into its most significant bit so the caller
//               can derive signed overflow on the top slice.
// Ports       : a, b  - slice operands
//               cin   - carry in
//               sum   - slice sum
//               cout  - carry out of the slice MSB
//               cmsb  - carry into the slice MSB
// Revision    : 1.0 - initial release
// ============================================================================
module slice_adder #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE:0] w_carry;

    always_comb begin
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
        end
    end

    assign cout = w_carry[SLICE];
    assign cmsb = w_carry[SLICE-1];

endmodule : slice_adder
`default_nettype wire

// File: rtl/add_sub_seq.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_seq
// Description : Multi-cycle two's-complement add/subtract unit. One SLICE-bit
//               chunk is added per clock through a single time-multiplexed
//               slice_adder, giving a short carry path at the cost of NSLICE
//               cycles of latency. Valid/ready handshake on input and output.
// Config      : ADD_SUB_SATURATE_EN - when defined, an overflowing result is
//               clamped to SAT_MAX / SAT_MIN (chosen by the sign of A). The
//               saturation limits assume WIDTH == DATA_WIDTH.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid / in_ready  - operand handshake (ready only in IDLE)
//               op                   - 0 = A+B, 1 = A-B
//               a, b                 - signed operands
//               out_valid / out_ready- result handshake (valid only in DONE)
//               result, overflow     - sum/difference and signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_t r_state;
    state_t w_next;

    // Operands and result viewed as an array of slices so the active slice
    // can be selected directly by the slice counter.
    logic [NSLICE-1:0][SLICE-1:0] r_a;
    logic [NSLICE-1:0][SLICE-1:0] r_b;
    logic [NSLICE-1:0][SLICE-1:0] r_result;
    logic                         r_carry;
    logic                         r_overflow;
    logic [CNT_W-1:0]             r_cnt;

    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_accept;
    logic             w_last;
    logic             w_ovf;

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .a    (r_a[r_cnt]),
        .b    (r_b[r_cnt]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == CALC) && (r_cnt == LAST_CNT);
    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    assign w_ovf    = w_cmsb ^ w_cout;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 enters as carry.
            r_a     <= a;
            r_b     <= (op == OP_SUB) ? ~b : b;
            r_carry <= op;
            r_cnt   <= '0;
        end else if (r_state == CALC) begin
            r_result[r_cnt] <= w_sum;
            r_carry         <= w_cout;
            r_cnt           <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_overflow <= w_ovf;
`ifdef ADD_SUB_SATURATE_EN
                // Overflow can only occur when A and B' share a sign, so the
                // sign of A gives the direction of the true result.
                if (w_ovf) begin
                    r_result <= r_a[NSLICE-1][SLICE-1] ? SAT_MIN : SAT_MAX;
                end
`endif
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;

endmodule : add_sub_seq
`default_nettype wire
